// File: rtl/piso_stream_pkg.sv
// piso_stream shared types: frame states, bit-order codes, counter sizing.
// Optional parity stage is enabled with PISO_PARITY_EN.
package piso_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t PAR   = 2'd2;

  localparam logic ORDER_MSB = 1'b0;
  localparam logic ORDER_LSB = 1'b1;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/piso_stream_if.sv
// Parallel load handshake between a word producer and piso_stream.
// master = producer, slave = serialiser.
interface piso_stream_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] parallel_in;
  logic             lsb_first;

  modport master (
    output in_valid,
    output parallel_in,
    output lsb_first,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  parallel_in,
    input  lsb_first,
    output in_ready
  );

endinterface

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with zero flag; load wins over decrement.
// Saturates at zero.
module piso_bit_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = load_val_i;
    else if (dec_i && cnt_q != '0)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with valid/ready load and bit-order select.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  piso_stream_if.slave   ld_if,
  output logic           serial_out,
  output logic           serial_valid,
  output logic           busy,
  output logic           done
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
`ifdef PISO_PARITY_EN
  localparam logic [CNT_W-1:0] DONE_AT = '0;
`else
  localparam logic [CNT_W-1:0] DONE_AT = CNT_W'(1);
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             order_q, order_d;
  logic             sout_q, sout_d;
  logic             sval_q, sval_d;
  logic             done_q, done_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;
  logic             cnt_load;
  logic             cnt_dec;
  logic             accept;
  logic             last_data;
  logic             window;

  piso_bit_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (LAST),
    .cnt_o      (cnt),
    .zero_o     (cnt_zero)
  );

  assign last_data = (state_q == SHIFT) && cnt_zero;
`ifdef PISO_PARITY_EN
  assign window = (state_q == PAR);
`else
  assign window = last_data;
`endif

  assign ld_if.in_ready = !rst && ((state_q == IDLE) || window);
  assign accept = ld_if.in_valid && ld_if.in_ready;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    order_d  = order_q;
    sout_d   = sout_q;
    sval_d   = sval_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d    = par_q;
`endif
    // done is registered, so raise it one cycle before the final bit shows
    done_d   = (state_q == SHIFT) && (cnt == DONE_AT);
    if (accept) begin
      state_d  = SHIFT;
      order_d  = ld_if.lsb_first;
      sval_d   = 1'b1;
      cnt_load = 1'b1;
`ifdef PISO_PARITY_EN
      par_d    = ^ld_if.parallel_in;
`endif
      if (ld_if.lsb_first == ORDER_LSB) begin
        sout_d = ld_if.parallel_in[0];
        sr_d   = ld_if.parallel_in >> 1;
      end else begin
        sout_d = ld_if.parallel_in[WIDTH-1];
        sr_d   = ld_if.parallel_in << 1;
      end
    end else begin
      unique case (1'b1)
        (state_q == IDLE): begin
          sout_d = 1'b0;
          sval_d = 1'b0;
        end
        (state_q == SHIFT && !cnt_zero): begin
          cnt_dec = 1'b1;
          sval_d  = 1'b1;
          if (order_q == ORDER_LSB) begin
            sout_d = sr_q[0];
            sr_d   = sr_q >> 1;
          end else begin
            sout_d = sr_q[WIDTH-1];
            sr_d   = sr_q << 1;
          end
        end
`ifdef PISO_PARITY_EN
        last_data: begin
          state_d = PAR;
          sout_d  = par_q;
          sval_d  = 1'b1;
        end
`endif
        default: begin
          state_d = IDLE;
          sout_d  = 1'b0;
          sval_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      order_q <= ORDER_MSB;
      sout_q  <= 1'b0;
      sval_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      order_q <= order_d;
      sout_q  <= sout_d;
      sval_q  <= sval_d;
      done_q  <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign serial_out   = sout_q;
  assign serial_valid = sval_q;
  assign busy         = sval_q;
  assign done         = done_q;

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
Parametrised parallel-in/serial-out shifter with a valid/ready load handshake and a runtime bit-order select.
- Accepts a WIDTH-bit word, then emits it one bit per clock on serial_out, qualified by serial_valid.
- Pulses done on the final bit of each frame.
- Can accept the next word on the final bit cycle, so frames stream back-to-back with no gap.
- Sits between parallel datapath producers and serial links or test pins in the design.

Parameters:
WIDTH, 8, bits per word; legal range 2..32.
CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  parallel_in holds a word to load
in_ready  output  1  block will accept a word this cycle
parallel_in  input  WIDTH  word to serialise
lsb_first  input  1  bit order for this word; 0 = MSB first, 1 = LSB first
serial_out  output  1  current serial bit; registered
serial_valid  output  1  serial_out carries a frame bit; registered
busy  output  1  a frame is in progress; equals serial_valid
done  output  1  one-cycle pulse, high with the last bit of a frame; registered

Behaviour:
- One clock. Reset is synchronous and active-high on clk/rst.
- Reset values: serial_out=0, serial_valid=0, busy=0, done=0, state=IDLE, counter=0, shift register=0. in_ready is forced 0 while rst is high.
- States:
  - IDLE: in_ready=1.
  - SHIFT: in_ready=1 only when the counter is 0 (last bit).
  - PAR: exists only with the optional feature; see below.
- Accept: in_valid && in_ready at a rising edge.
  - The word and lsb_first are captured together.
  - State goes to SHIFT and the counter loads WIDTH-1.
- Latency: the first bit appears on serial_out in the cycle after accept. Bits occupy WIDTH consecutive cycles with serial_valid=1.
- Bit order:
  - MSB-first emits parallel_in[WIDTH-1] down to [0].
  - LSB-first emits [0] up to [WIDTH-1].
  - The order is fixed for the whole frame; lsb_first changes mid-frame have no effect.
- In SHIFT with counter>0: shift the register one bit per cycle and decrement the counter.
- Last bit (counter==0):
  - done=1 in this cycle.
  - With an accept: reload and stay in SHIFT. The next frame's first bit follows immediately.
  - Without an accept: go to IDLE. serial_valid=0 and serial_out=0 from the next cycle.
- in_valid while in_ready=0 is ignored. The source must hold parallel_in and in_valid until accepted; no data is lost or overwritten.
- In IDLE: serial_out is held 0 and done=0.
- Reset mid-frame: the frame is abandoned immediately. No done pulse, and outputs go to reset values on the next edge.
- rst and in_valid both high: reset wins and nothing is captured.

Optional Feature:
PISO_PARITY_EN
- Defined:
  - After the WIDTH data bits, state PAR emits one extra bit equal to the even-parity XOR of the captured word, with serial_valid=1.
  - Frame length is WIDTH+1.
  - done and the last-bit accept window move from the final data bit to the PAR cycle.
- Undefined: PAR state and parity logic are absent and frames are WIDTH bits.

Decomposition:
- Package piso_pkg holds:
  - the state typedef (IDLE, SHIFT, PAR);
  - the ORDER_MSB/ORDER_LSB constants;
  - a function computing the counter width from WIDTH.
- One natural sub-module: piso_bit_counter. It is a loadable down-counter with a zero flag, reused by the frame FSM.
- The shift register and FSM stay in piso_stream.

Test Plan:
- WIDTH=4, accept 4'b1011 with lsb_first=0 at cycle T: serial_out=1,0,1,1 at T+1..T+4, serial_valid=1 for exactly those cycles, done=1 only at T+4, in_ready=1 again at T+4.
- WIDTH=4, accept 4'b1011 with lsb_first=1: serial_out=1,1,0,1, done at the 4th bit.
- WIDTH=8, in_valid held high with 8'hA5 then 8'h3C: 16 contiguous serial_valid cycles carrying 10100101 then 00111100, two done pulses, no gap cycle.
- WIDTH=8, accept 8'hFF, pulse rst after the 3rd bit: next cycle serial_valid=0 and serial_out=0, no done, in_ready=1 one cycle after rst deasserts.
- WIDTH=8, accept 8'h81, present 8'h00 with in_valid=1 from bit 2 onward: 8'h00 is not captured until the last-bit cycle and then streams intact; 8'h81's bits are unaffected.
- PISO_PARITY_EN: 8'hA5 gives a parity bit of 0 in the 9th cycle, and 8'h07 gives 1; done coincides with the parity bit.
